score_tracker: RTL and testbench



---
 rtl/dino_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 27 ++
 rtl/score_tracker.sv | 126 ++++++++++++
 tb/tb_score_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the score tracker.
// State encoding, BCD geometry and the saturation value.
package dino_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_OVER    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUNNING = ST_RUNNING,
    OVER    = ST_OVER
  } state_t;

  localparam int DIGIT_W      = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = DIGIT_W * SCORE_DIGITS;

  localparam logic [SCORE_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..9 on inc_in, wraps with carry_out.
// Chained to build the multi-digit score.
module bcd_digit
  import dino_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc_in,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  assign carry_out = inc_in && (value == DIGIT_W'(9));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc_in) begin
      if (value == DIGIT_W'(9))
        value <= '0;
      else
        value <= value + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Game score / speed-level tracker fed by controller event pulses.
// Optional high score: define SCORE_TRACKER_HIGH_SCORE_EN.
module score_tracker
  import dino_pkg::*;
#(
  parameter int SCORE_DIV = 6,
  parameter int LEVEL_MAX = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  game_tick,
  input  logic        game_start_pulse,
  input  logic        game_over_pulse,
  output logic        running,
  output logic [15:0] score_bcd,
  output logic [15:0] high_score_bcd,
  output logic [2:0]  speed_level,
  output logic        level_up_pulse,
  output logic        new_high_pulse
);

  localparam int PW =
    (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP =
    PW'(SCORE_DIV - 1);
  localparam logic [2:0] LVL_TOP = 3'(LEVEL_MAX);

  state_t              state;
  logic [PW-1:0]       presc;
  logic [SCORE_DIGITS:0] carry;
  logic                score_inc;
  logic                clear_score;
  logic                tick;
  logic                unused_tick;
  logic                unused_carry;

  assign tick         = game_tick[0];
  assign unused_tick  = game_tick[1];
  assign unused_carry = carry[SCORE_DIGITS];

  // Over beats a scoring tick; 9999 gates the chain so it saturates.
  assign score_inc = (state == RUNNING) && tick
                  && !game_over_pulse
                  && (presc == PRE_TOP)
                  && (score_bcd != BCD_MAX);

  assign clear_score = game_start_pulse
                    && (state != RUNNING);

  assign carry[0] = score_inc;

  for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_score),
      .inc_in    (carry[i]),
      .value     (score_bcd[i*DIGIT_W +: DIGIT_W]),
      .carry_out (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      running        <= 1'b0;
      presc          <= '0;
      speed_level    <= '0;
      level_up_pulse <= 1'b0;
    end else begin
      level_up_pulse <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (game_start_pulse) begin
            state       <= RUNNING;
            running     <= 1'b1;
            presc       <= '0;
            speed_level <= '0;
          end
        end
        RUNNING: begin
          if (game_over_pulse) begin
            state   <= OVER;
            running <= 1'b0;
          end else begin
            if (tick)
              presc <= (presc == PRE_TOP) ? '0
                     : presc + PW'(1);
            // Carry out of tens: crossed a multiple of 100.
            if (carry[2] && speed_level < LVL_TOP) begin
              speed_level    <= speed_level + 3'd1;
              level_up_pulse <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  logic hs_update;

  assign hs_update = (state == RUNNING)
                  && game_over_pulse
                  && (score_bcd > high_score_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      high_score_bcd <= '0;
      new_high_pulse <= 1'b0;
    end else begin
      new_high_pulse <= hs_update;
      if (hs_update)
        high_score_bcd <= score_bcd;
    end
  end
`else
  assign high_score_bcd = '0;
  assign new_high_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (SCORE_DIV=6, LEVEL_MAX=7).
// High-score expectations follow SCORE_TRACKER_HIGH_SCORE_EN.
module tb_score_tracker;

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  localparam logic HS = 1'b1;
`else
  localparam logic HS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  game_tick = 2'b00;
  logic        game_start_pulse = 1'b0;
  logic        game_over_pulse = 1'b0;
  logic        running;
  logic [15:0] score_bcd;
  logic [15:0] high_score_bcd;
  logic [2:0]  speed_level;
  logic        level_up_pulse;
  logic        new_high_pulse;

  int checks = 0;
  int errors = 0;
  int lvl_pulses = 0;

  always #5 clk = ~clk;

  score_tracker #(.SCORE_DIV(6), .LEVEL_MAX(7)) dut (
    .clk              (clk),
    .reset            (reset),
    .game_tick        (game_tick),
    .game_start_pulse (game_start_pulse),
    .game_over_pulse  (game_over_pulse),
    .running          (running),
    .score_bcd        (score_bcd),
    .high_score_bcd   (high_score_bcd),
    .speed_level      (speed_level),
    .level_up_pulse   (level_up_pulse),
    .new_high_pulse   (new_high_pulse)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t,
                       input logic s,
                       input logic o);
    @(negedge clk);
    game_tick = t;
    game_start_pulse = s;
    game_over_pulse = o;
    @(posedge clk);
    #1;
    game_tick = 2'b00;
    game_start_pulse = 1'b0;
    game_over_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      drive(2'b01, 1'b0, 1'b0);
      if (level_up_pulse) lvl_pulses++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_score"}, score_bcd, 16'h0000);
    check({tag, "_high"}, high_score_bcd, 16'h0000);
    check({tag, "_level"}, speed_level, 3'd0);
    check({tag, "_run"}, running, 1'b0);
    check({tag, "_lvup"}, level_up_pulse, 1'b0);
    check({tag, "_newhi"}, new_high_pulse, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("rst");

    // Ticks in IDLE do nothing
    ticks(6);
    check("idle_score", score_bcd, 16'h0000);
    check("idle_run", running, 1'b0);

    drive(2'b00, 1'b1, 1'b0);
    check("start_run", running, 1'b1);
    ticks(5);
    check("tick5", score_bcd, 16'h0000);
    ticks(1);
    check("tick6", score_bcd, 16'h0001);

    ticks(588);
    check("s99", score_bcd, 16'h0099);
    check("s99_lvl", speed_level, 3'd0);
    lvl_pulses = 0;
    ticks(5);
    check("s99_lvup", level_up_pulse, 1'b0);
    ticks(1);
    check("s100", score_bcd, 16'h0100);
    check("s100_lvl", speed_level, 3'd1);
    check("s100_lvup", level_up_pulse, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    check("s100_lvup_off", level_up_pulse, 1'b0);

    ticks(9898 * 6);
    check("s9998", score_bcd, 16'h9998);
    check("s9998_lvl", speed_level, 3'd7);
    check("lvl_pulses", lvl_pulses, 7);
    lvl_pulses = 0;
    ticks(6);
    check("s9999", score_bcd, 16'h9999);
    ticks(6);
    check("s9999_sat", score_bcd, 16'h9999);
    check("sat_pulses", lvl_pulses, 0);
    check("sat_lvl", speed_level, 3'd7);

    drive(2'b00, 1'b0, 1'b1);
    check("over9999_run", running, 1'b0);
    check("over9999_hi", high_score_bcd,
          HS ? 16'h9999 : 16'h0000);
    check("over9999_nh", new_high_pulse, HS);
    drive(2'b00, 1'b0, 1'b0);
    check("over9999_nh_off", new_high_pulse, 1'b0);

    do_reset();
    check_cleared("rst2");

    // Over coincident with a scoring tick at 0041
    drive(2'b00, 1'b1, 1'b0);
    ticks(246);
    check("s41", score_bcd, 16'h0041);
    ticks(5);
    drive(2'b01, 1'b0, 1'b1);
    check("ov41_run", running, 1'b0);
    check("ov41_score", score_bcd, 16'h0041);
    ticks(6);
    check("ov41_frozen", score_bcd, 16'h0041);
    drive(2'b00, 1'b0, 1'b1);
    check("ov41_overign", running, 1'b0);
    drive(2'b00, 1'b1, 1'b0);
    check("restart_score", score_bcd, 16'h0000);
    check("restart_lvl", speed_level, 3'd0);
    check("restart_run", running, 1'b1);

    // Game 1: over at 0057
    ticks(342);
    check("g1_score", score_bcd, 16'h0057);
    drive(2'b00, 1'b0, 1'b1);
    check("g1_nh", new_high_pulse, HS);
    check("g1_hi", high_score_bcd,
          HS ? 16'h0057 : 16'h0000);
    drive(2'b00, 1'b0, 1'b0);
    check("g1_nh_off", new_high_pulse, 1'b0);

    // Game 2: equal score, start mid-run ignored
    drive(2'b00, 1'b1, 1'b0);
    ticks(300);
    drive(2'b00, 1'b1, 1'b0);
    check("g2_startign", score_bcd, 16'h0050);
    ticks(42);
    check("g2_score", score_bcd, 16'h0057);
    drive(2'b00, 1'b0, 1'b1);
    check("g2_nh", new_high_pulse, 1'b0);
    check("g2_hi", high_score_bcd,
          HS ? 16'h0057 : 16'h0000);

    // Game 3: over at 0112
    drive(2'b00, 1'b1, 1'b0);
    ticks(672);
    check("g3_score", score_bcd, 16'h0112);
    check("g3_lvl", speed_level, 3'd1);
    drive(2'b00, 1'b0, 1'b1);
    check("g3_nh", new_high_pulse, HS);
    check("g3_hi", high_score_bcd,
          HS ? 16'h0112 : 16'h0000);

    // Reset mid-game at 0230
    drive(2'b00, 1'b1, 1'b0);
    ticks(1380);
    check("s230", score_bcd, 16'h0230);
    check("s230_lvl", speed_level, 3'd2);
    do_reset();
    check_cleared("rst3");
    ticks(6);
    check("rst3_ign", score_bcd, 16'h0000);
    check("rst3_ign_run", running, 1'b0);
    drive(2'b00, 1'b1, 1'b0);
    ticks(6);
    check("rst3_restart", score_bcd, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
